// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Two-client round-robin arbiter in front of a single-port RAM.
//            Each client issues read/write commands over valid/ready. At most
//            one RAM access is issued per cycle, and read data goes back to
//            the issuing client one cycle after acceptance.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            req<i>_valid/ready/we/addr/wdata - client <i> command channel
//            rsp<i>_valid/rdata            - client <i> read response (1-cycle pulse)
//            ram_enable/read_en/address/data_in - RAM command, sole driver
//            ram_data_out                  - RAM read data (1 cycle after access)
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    // client 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_we,
    input  logic [ADDR-1:0]  req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_rdata,
    // client 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_we,
    input  logic [ADDR-1:0]  req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_rdata,
    // RAM
    output logic             ram_enable,
    output logic             ram_read_en,
    output logic [ADDR-1:0]  ram_address,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
);

    // Client identifiers, used for the priority pointer and the response tag.
    localparam logic [0:0] c_CLIENT0 = 1'b0;
    localparam logic [0:0] c_CLIENT1 = 1'b1;

    logic [0:0]       r_last_gnt;   // client granted most recently
    logic             r_rd_pend;    // a read was issued in the previous cycle
    logic [0:0]       r_rd_id;      // which client issued that read

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any_gnt;
    logic             w_we;
    logic [ADDR-1:0]  w_addr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_rd_issue;

    // ------------------------------------------------------------------
    // Grant: a lone requester always wins; on a tie the client that was
    // not granted last wins. Nothing is granted while in reset, so a
    // command presented during reset is simply not accepted.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            w_gnt0 = req0_valid && (!req1_valid || (r_last_gnt == c_CLIENT1));
            w_gnt1 = req1_valid && (!req0_valid || (r_last_gnt == c_CLIENT0));
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_any_gnt  = w_gnt0 | w_gnt1;

    // Granted command, selected by grant (client 0 when nothing is granted;
    // the RAM drive below masks it back to idle in that case).
    assign w_we    = w_gnt1 ? req1_we    : req0_we;
    assign w_addr  = w_gnt1 ? req1_addr  : req0_addr;
    assign w_wdata = w_gnt1 ? req1_wdata : req0_wdata;

    // ------------------------------------------------------------------
    // RAM drive. Idle values: enable=0, read_en=1, address=0, data_in=0.
    // ------------------------------------------------------------------
    always_comb begin
        ram_enable  = 1'b0;
        ram_read_en = 1'b1;
        ram_address = '0;
        ram_data_in = '0;
        if (w_any_gnt) begin
            ram_enable  = 1'b1;
            ram_read_en = ~w_we;
            ram_address = w_addr;
            ram_data_in = w_we ? w_wdata : '0;
        end
    end

    assign w_rd_issue = w_any_gnt & ~w_we;

    // ------------------------------------------------------------------
    // Priority pointer: moves only when something is granted. Reset points
    // it at client 1 so that client 0 wins the first tie.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= c_CLIENT1;
        end else if (w_gnt0) begin
            r_last_gnt <= c_CLIENT0;
        end else if (w_gnt1) begin
            r_last_gnt <= c_CLIENT1;
        end
    end

    // ------------------------------------------------------------------
    // Response tag, captured every edge. The RAM presents read data in the
    // cycle after the access, which is exactly when this tag is valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_id   <= c_CLIENT0;
        end else begin
            r_rd_pend <= w_rd_issue;
            r_rd_id   <= w_gnt1 ? c_CLIENT1 : c_CLIENT0;
        end
    end

    // Response steering: only the tagged client sees data, the other gets 0.
    always_comb begin
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        if (r_rd_pend) begin
            if (r_rd_id == c_CLIENT1) begin
                rsp1_valid = 1'b1;
                rsp1_rdata = ram_data_out;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_rdata = ram_data_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Directed self-checking bench for ram_port_arbiter, with a
//            behavioural single-port RAM attached to the RAM ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready, req0_we;
    logic [ADDR-1:0]  req0_addr;
    logic [WIDTH-1:0] req0_wdata;
    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_rdata;
    logic             req1_valid, req1_ready, req1_we;
    logic [ADDR-1:0]  req1_addr;
    logic [WIDTH-1:0] req1_wdata;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_rdata;
    logic             ram_enable, ram_read_en;
    logic [ADDR-1:0]  ram_address;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] ram_data_out;

    int n_cmp;
    int n_err;

    ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_enable(ram_enable), .ram_read_en(ram_read_en),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    // Behavioural single-port RAM: access on enabled edge, read data next cycle.
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (ram_enable) begin
            if (ram_read_en) ram_data_out <= mem[ram_address];
            else             mem[ram_address] <= ram_data_in;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, apply a command set, then
    // let combinational outputs settle before any checks.
    task automatic drive(input logic v0, input logic we0, input logic [ADDR-1:0] a0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic we1, input logic [ADDR-1:0] a1, input logic [WIDTH-1:0] d1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'h3; req0_wdata = 8'h00;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'h4; req1_wdata = 8'h77;
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0 actual=%b required=0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1 actual=%b required=0", req1_ready); end
        n_cmp++; if (ram_enable !== 1'b0) begin n_err++; $display("FAIL rst_enable actual=%b required=0", ram_enable); end
        n_cmp++; if (ram_read_en !== 1'b1) begin n_err++; $display("FAIL rst_read_en actual=%b required=1", ram_read_en); end
        n_cmp++; if (ram_address !== 4'h0) begin n_err++; $display("FAIL rst_address actual=%h required=0", ram_address); end
        n_cmp++; if (ram_data_in !== 8'h00) begin n_err++; $display("FAIL rst_data_in actual=%h required=00", ram_data_in); end
        @(posedge clk); #1;
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid actual=%b%b required=00", rsp0_valid, rsp1_valid); end
        n_cmp++; if (rsp0_rdata !== 8'h00 || rsp1_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rsp_rdata actual=%h/%h required=00/00", rsp0_rdata, rsp1_rdata); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single_client();
        logic [WIDTH-1:0] exp_d [3];
        exp_d[0] = 8'hAA; exp_d[1] = 8'h11; exp_d[2] = 8'h12;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'(i), exp_d[i], 1'b0, 1'b0, 4'h0, 8'h00);
            n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready0[%0d] actual=%b required=1", i, req0_ready); end
            n_cmp++; if ({ram_enable, ram_read_en, ram_address, ram_data_in} !== {1'b1, 1'b0, 4'(i), exp_d[i]})
                begin n_err++; $display("FAIL wr_ram[%0d] actual=%b%b/%h/%h required=10/%h/%h", i, ram_enable, ram_read_en, ram_address, ram_data_in, 4'(i), exp_d[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 1'b0, 4'(i), 8'hFF, 1'b0, 1'b0, 4'h0, 8'h00);
            else       idle();
            if (i < 3) begin
                n_cmp++; if (req0_ready !== 1'b1 || ram_read_en !== 1'b1 || ram_data_in !== 8'h00)
                    begin n_err++; $display("FAIL rd_issue[%0d] actual=%b%b/%h required=11/00", i, req0_ready, ram_read_en, ram_data_in); end
            end
            if (i > 0) begin
                n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== exp_d[i-1])
                    begin n_err++; $display("FAIL rd_rsp0[%0d] actual=%b/%h required=1/%h", i-1, rsp0_valid, rsp0_rdata, exp_d[i-1]); end
                n_cmp++; if (rsp1_valid !== 1'b0 || rsp1_rdata !== 8'h00)
                    begin n_err++; $display("FAIL rd_rsp1_quiet[%0d] actual=%b/%h required=0/00", i-1, rsp1_valid, rsp1_rdata); end
            end
        end
        idle();
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp0_end actual=%b required=0", rsp0_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
            else       idle();
            if (i < 4) begin
                n_cmp++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                    begin n_err++; $display("FAIL rr_grant[%0d] actual=%b%b required=%s", i, req0_ready, req1_ready, (i % 2 == 0) ? "10" : "01"); end
            end
            if (i > 0) begin
                if (i % 2 == 1) begin
                    n_cmp++; if ({rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata} !== {1'b1, 8'h11, 1'b0, 8'h00})
                        begin n_err++; $display("FAIL rr_rsp_c0[%0d] actual=%b/%h %b/%h required=1/11 0/00", i, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata); end
                end else begin
                    n_cmp++; if ({rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata} !== {1'b0, 8'h00, 1'b1, 8'h12})
                        begin n_err++; $display("FAIL rr_rsp_c1[%0d] actual=%b/%h %b/%h required=0/00 1/12", i, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata); end
                end
            end
        end
    endtask

    task automatic test_raw_hazard();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h5, 8'h55);
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL raw_wr_ready1 actual=%b required=1", req1_ready); end
        drive(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        n_cmp++; if (req0_ready !== 1'b1 || ram_address !== 4'h5) begin n_err++; $display("FAIL raw_rd_issue actual=%b/%h required=1/5", req0_ready, ram_address); end
        idle();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'h55) begin n_err++; $display("FAIL raw_rsp0 actual=%b/%h required=1/55", rsp0_valid, rsp0_rdata); end
    endtask

    task automatic test_idle();
        // Last grant before this went to client 0.
        for (int i = 0; i < 3; i++) begin
            idle();
            n_cmp++; if ({ram_enable, ram_read_en, ram_address} !== {1'b0, 1'b1, 4'h0})
                begin n_err++; $display("FAIL idle_ram[%0d] actual=%b%b/%h required=01/0", i, ram_enable, ram_read_en, ram_address); end
            n_cmp++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0000)
                begin n_err++; $display("FAIL idle_quiet[%0d] actual=%b%b%b%b required=0000", i, rsp0_valid, rsp1_valid, req0_ready, req1_ready); end
        end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h1, 8'h00);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL idle_tie actual=%b%b required=01", req0_ready, req1_ready); end
        idle();
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 8'h11) begin n_err++; $display("FAIL idle_tie_rsp1 actual=%b/%h required=1/11", rsp1_valid, rsp1_rdata); end
    endtask

    task automatic test_reset_drop();
        // Make client 0 the last grantee so the reset pointer change is visible.
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rd_pre_ready0 actual=%b required=1", req0_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b0 || ram_enable !== 1'b0) begin n_err++; $display("FAIL rd_rst_block actual=%b%b required=00", req0_ready, ram_enable); end
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL rd_rst_dropped actual=%b%b required=00", rsp0_valid, rsp1_valid); end
        drive(1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rd_post_tie actual=%b%b required=10", req0_ready, req1_ready); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
            n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1[%0d] actual=%b required=1", i, req1_ready); end
            if (i > 0) begin
                n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 8'h12) begin n_err++; $display("FAIL b2b_rsp1[%0d] actual=%b/%h required=1/12", i, rsp1_valid, rsp1_rdata); end
            end
        end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL b2b_join actual=%b%b required=10", req0_ready, req1_ready); end
        idle();
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'hAA) begin n_err++; $display("FAIL b2b_join_rsp0 actual=%b/%h required=1/AA", rsp0_valid, rsp0_rdata); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        test_reset();
        test_single_client();
        test_round_robin();
        test_raw_hazard();
        test_idle();
        test_reset_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
